// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared constants and entry type for the fetch/decode queue
package inst_fetch_queue_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam int          IFQ_DEPTH = 4;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifqEntry_t;

    // An address-error entry must never reach the decoder as a real opcode.
    function automatic logic [31:0] decodeWord(input ifqEntry_t e);
        return e.adel ? NOP_INST : e.instr;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupling FIFO between fetch and decode, NOP on empty, flush on redirect
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = IFQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushD,
    input  logic             stallD,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    input  logic             if_adel,
    output logic             validD,
    output logic [31:0]      instrD,
    output logic [31:0]      pcD,
    output logic             adelD,
    output logic [PTR_W:0]   countD
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ifqEntry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    ifqEntry_t        head;

    // Ready depends only on occupancy and flush, so stallD never reaches the fetch side.
    assign if_ready = (count != FULL_COUNT) && !flushD;
    assign validD   = (count != '0);
    assign push     = if_valid && if_ready;
    assign pop      = validD && !stallD;
    assign head     = mem[rdPtr];

    always_comb begin
        instrD = NOP_INST;
        pcD    = 32'h0;
        adelD  = 1'b0;
        if (validD) begin
            instrD = decodeWord(head);
            pcD    = head.pc;
            adelD  = head.adel;
        end
    end

    assign countD = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= '{adel: if_adel, pc: if_pc, instr: if_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushD;
    logic        stallD;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_adel;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        adelD;
    logic [2:0]  countD;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue dut (
        .clk      (clk),
        .rst      (rst),
        .flushD   (flushD),
        .stallD   (stallD),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .if_adel  (if_adel),
        .validD   (validD),
        .instrD   (instrD),
        .pcD      (pcD),
        .adelD    (adelD),
        .countD   (countD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flushD = 1'b0; stallD = 1'b0;
        if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; if_adel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (validD !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", validD); end
        checks++;
        if (countD !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", countD); end
        checks++;
        if (instrD !== 32'h0 || pcD !== 32'h0 || adelD !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got instr=%h pc=%h adel=%0b want zeros", instrD, pcD, adelD);
        end
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", if_ready); end
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'hBFC0_0000; if_instr = 32'h2401_0001; if_adel = 1'b0;
        tick();
        if_valid = 1'b0;
        checks++;
        if (validD !== 1'b1 || instrD !== 32'h2401_0001 || pcD !== 32'hBFC0_0000) begin
            errors++; $display("FAIL single_head got v=%0b instr=%h pc=%h want 1 24010001 bfc00000", validD, instrD, pcD);
        end
        checks++;
        if (countD !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", countD); end
        tick();
        checks++;
        if (countD !== 3'd0 || validD !== 1'b0) begin
            errors++; $display("FAIL single_pop got count=%0d v=%0b want 0 0", countD, validD);
        end
    endtask

    task automatic test_full();
        stallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'h1000 + 32'(4 * i); if_instr = 32'hA0 + 32'(i);
            tick();
        end
        checks++;
        if (countD !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", countD); end
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", if_ready); end
        if_pc = 32'h1010; if_instr = 32'hA4;
        tick();
        checks++;
        if (countD !== 3'd4 || pcD !== 32'h1000) begin
            errors++; $display("FAIL full_hold got count=%0d pc=%h want 4 00001000", countD, pcD);
        end
        stallD = 1'b0;
        tick();
        if_valid = 1'b0;
        // First drain edge happened with if_ready=0, so the held 5th entry must not appear.
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pcD !== 32'h1000 + 32'(4 * i) || instrD !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL drain_%0d got pc=%h instr=%h want %h %h", i, pcD, instrD,
                                   32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            tick();
        end
        checks++;
        if (countD !== 3'd0 || validD !== 1'b0) begin
            errors++; $display("FAIL drain_empty got count=%0d v=%0b want 0 0", countD, validD);
        end
    endtask

    task automatic test_back_to_back();
        if_valid = 1'b1; if_pc = 32'h2000; if_instr = 32'h1111_0000;
        tick();
        for (int k = 1; k <= 10; k++) begin
            if_pc = 32'h2000 + 32'(4 * k); if_instr = 32'h1111_0000 + 32'(k);
            checks++;
            if (countD !== 3'd1 || pcD !== 32'h2000 + 32'(4 * (k - 1))) begin
                errors++; $display("FAIL stream_%0d got count=%0d pc=%h want 1 %h", k, countD, pcD,
                                   32'h2000 + 32'(4 * (k - 1)));
            end
            tick();
        end
        if_valid = 1'b0;
        checks++;
        if (pcD !== 32'h2028 || instrD !== 32'h1111_000A) begin
            errors++; $display("FAIL stream_last got pc=%h instr=%h want 00002028 1111000a", pcD, instrD);
        end
        tick();
        checks++;
        if (countD !== 3'd0) begin errors++; $display("FAIL stream_empty got %0d want 0", countD); end
    endtask

    task automatic test_flush();
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h3000 + 32'(4 * i); if_instr = 32'hC0 + 32'(i);
            tick();
        end
        checks++;
        if (countD !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", countD); end
        if_pc = 32'h300C; if_instr = 32'hC3; flushD = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", if_ready); end
        tick();
        flushD = 1'b0; if_valid = 1'b0; stallD = 1'b0;
        checks++;
        if (validD !== 1'b0 || instrD !== 32'h0 || countD !== 3'd0 || pcD !== 32'h0) begin
            errors++; $display("FAIL flush_empty got v=%0b instr=%h count=%0d pc=%h want zeros", validD, instrD, countD, pcD);
        end
        tick();
        checks++;
        if (countD !== 3'd0) begin errors++; $display("FAIL flush_absent got %0d want 0", countD); end
    endtask

    task automatic test_adel();
        stallD = 1'b1;
        if_valid = 1'b1; if_pc = 32'hBFC0_0002; if_instr = 32'hDEAD_BEEF; if_adel = 1'b1;
        tick();
        if_valid = 1'b0; if_adel = 1'b0;
        checks++;
        if (validD !== 1'b1 || adelD !== 1'b1 || instrD !== 32'h0 || pcD !== 32'hBFC0_0002) begin
            errors++; $display("FAIL adel_head got v=%0b adel=%0b instr=%h pc=%h want 1 1 0 bfc00002",
                               validD, adelD, instrD, pcD);
        end
        stallD = 1'b0;
        tick();
        checks++;
        if (adelD !== 1'b0 || validD !== 1'b0) begin
            errors++; $display("FAIL adel_pop got adel=%0b v=%0b want 0 0", adelD, validD);
        end
    endtask

    task automatic test_rst_mid();
        stallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_valid = 1'b1; if_pc = 32'h4000 + 32'(4 * i); if_instr = 32'hE0 + 32'(i);
            tick();
        end
        if_valid = 1'b0; stallD = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (countD !== 3'd0 || validD !== 1'b0 || pcD !== 32'h0 || instrD !== 32'h0 || adelD !== 1'b0) begin
            errors++; $display("FAIL rst_mid got count=%0d v=%0b pc=%h instr=%h adel=%0b want zeros",
                               countD, validD, pcD, instrD, adelD);
        end
        if_valid = 1'b1; if_pc = 32'h5000; if_instr = 32'h5555_5555;
        tick();
        if_valid = 1'b0;
        checks++;
        if (pcD !== 32'h5000 || instrD !== 32'h5555_5555 || countD !== 3'd1) begin
            errors++; $display("FAIL rst_next got pc=%h instr=%h count=%0d want 00005000 55555555 1", pcD, instrD, countD);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_adel();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
